// File: rtl/wb_pkg.sv
// Shared types and constants for the csRISC write-back stage.
// The optional load extender is enabled with the WB_LOAD_EXT_EN macro.
package wb_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_PC  = 2;
    localparam int SRC_IMM = 3;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational sign/zero extender for sub-word loads. It is only instantiated
// when WB_LOAD_EXT_EN is defined.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = rdata;
        case (size)
            LS_BYTE: data = {{(DATA_W-8){~is_unsigned & rdata[7]}}, rdata[7:0]};
            LS_HALF: data = {{(DATA_W-16){~is_unsigned & rdata[15]}}, rdata[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_writeback_stage.sv
// Registered, back-pressured write-back stage: source select, load wait with
// timeout, and register-file write port. WB_LOAD_EXT_EN adds sub-word load extension.
module wb_writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SRC_N   = 4,
    parameter int MEM_SRC = SRC_MEM,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 255,
    localparam int SEL_W  = (SRC_N > 1) ? $clog2(SRC_N) : 1,
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [SRC_N*DATA_W-1:0] src_data,
    input  logic                    reg_write,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic                    mem_rvalid,
    input  logic [DATA_W-1:0]       mem_rdata,
`ifdef WB_LOAD_EXT_EN
    input  logic [1:0]              load_size,
    input  logic                    load_unsigned,
`endif
    output logic                    wb_en,
    output logic [ADDR_W-1:0]       wb_addr,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    stall,
    output logic                    mem_timeout
);

    localparam logic [SEL_W-1:0] MEM_SEL   = SEL_W'(MEM_SRC);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    wb_state_t          state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  src_word;
    logic [DATA_W-1:0]  load_data;
    logic               is_load;
    logic               capture;
    logic               commit;
    logic [ADDR_W-1:0]  commit_addr;
    logic [DATA_W-1:0]  commit_data;
    logic               timeout_hit;

    assign in_ready = (state == IDLE);
    assign stall    = ~in_ready;
    assign is_load  = (sel == MEM_SEL) && reg_write;

    // Out-of-range selects fall through to source 0.
    always_comb begin
        src_word = src_data[DATA_W-1:0];
        for (int k = 1; k < SRC_N; k++) begin
            if (sel == SEL_W'(k)) src_word = src_data[k*DATA_W +: DATA_W];
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [1:0] size_q;
    logic       unsigned_q;
    logic [1:0] ext_size;
    logic       ext_unsigned;

    // A same-cycle load uses the live attributes; a waiting load uses the latched ones.
    assign ext_size     = (state == IDLE) ? load_size     : size_q;
    assign ext_unsigned = (state == IDLE) ? load_unsigned : unsigned_q;

    wb_load_ext #(
        .DATA_W      (DATA_W)
    ) u_load_ext (
        .rdata       (mem_rdata),
        .size        (ext_size),
        .is_unsigned (ext_unsigned),
        .data        (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q     <= LS_WORD;
            unsigned_q <= 1'b0;
        end else if (capture) begin
            size_q     <= load_size;
            unsigned_q <= load_unsigned;
        end
    end
`else
    assign load_data = mem_rdata;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_next  = state;
        cnt_next    = cnt;
        capture     = 1'b0;
        commit      = 1'b0;
        commit_addr = rd_addr;
        commit_data = src_word;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_load) begin
                        if (mem_rvalid) begin
                            commit      = (rd_addr != '0);
                            commit_data = load_data;
                        end else begin
                            state_next = WAIT_MEM;
                            cnt_next   = '0;
                            capture    = 1'b1;
                        end
                    end else begin
                        commit = reg_write && (rd_addr != '0);
                    end
                end
            end
            WAIT_MEM: begin
                commit_addr = addr_q;
                commit_data = load_data;
                // Data arriving on the timeout cycle still wins.
                if (mem_rvalid) begin
                    commit     = (addr_q != '0);
                    state_next = IDLE;
                end else if (cnt == CNT_LIMIT) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            wb_en       <= commit;
            mem_timeout <= timeout_hit;
            if (capture) addr_q <= rd_addr;
            if (commit) begin
                wb_addr <= commit_addr;
                wb_data <= commit_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_writeback_stage.sv
// Scoreboard bench for wb_writeback_stage (SRC_N=3, TIMEOUT=4); the load
// extension cases run only when WB_LOAD_EXT_EN is defined.
module tb_wb_writeback_stage;
    import wb_pkg::*;

    typedef enum logic {EV_WRITE, EV_TIMEOUT} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [31:0] s0, s1, s2;
    logic [95:0] src_data;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        mem_timeout;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    ev_t  exp_q[$];

    assign src_data = {s2, s1, s0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wb_writeback_stage #(
        .DATA_W        (32),
        .SRC_N         (3),
        .MEM_SRC       (1),
        .ADDR_W        (5),
        .TIMEOUT       (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sel           (sel),
        .src_data      (src_data),
        .reg_write     (reg_write),
        .rd_addr       (rd_addr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
`ifdef WB_LOAD_EXT_EN
        .load_size     (load_size),
        .load_unsigned (load_unsigned),
`endif
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .stall         (stall),
        .mem_timeout   (mem_timeout)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{EV_WRITE, a, d, cyc + 1});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wb_en"},       32'(wb_en),       32'd0);
        check({tag, "_wb_addr"},     32'(wb_addr),     32'd0);
        check({tag, "_wb_data"},     wb_data,          32'd0);
        check({tag, "_in_ready"},    32'(in_ready),    32'd1);
        check({tag, "_stall"},       32'(stall),       32'd0);
        check({tag, "_mem_timeout"}, 32'(mem_timeout), 32'd0);
    endtask

    task automatic take(input ev_kind_t kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h at cycle %0d, expected no event",
                     kind, wb_addr, wb_data, cyc);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind",  32'(kind), 32'(e.kind));
        check("event_cycle", 32'(cyc),  32'(e.cyc));
        if (e.kind == EV_WRITE) begin
            check("wb_addr", 32'(wb_addr), 32'(e.addr));
            check("wb_data", wb_data,      e.data);
        end
    endtask

    // Monitor: consumes one expected event per observed output pulse.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wb_en === 1'b1)       take(EV_WRITE);
            if (mem_timeout === 1'b1) take(EV_TIMEOUT);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; sel = 2'd0; reg_write = 1'b0; rd_addr = 5'd0;
        s0 = 32'd0; s1 = 32'd0; s2 = 32'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        load_size = LS_WORD; load_unsigned = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // ALU result
        @(negedge clk);
        s0 = 32'h0000_1234; s1 = 32'hBAD0_0001; s2 = 32'h0000_0104;
        in_valid = 1'b1; sel = 2'd0; rd_addr = 5'd5; reg_write = 1'b1;
        expect_write(5'd5, 32'h0000_1234);
        @(negedge clk);
        in_valid = 1'b0;
        check("alu_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back non-loads
        @(negedge clk);
        in_valid = 1'b1; sel = 2'd0; s0 = 32'h0000_000A; rd_addr = 5'd3;
        expect_write(5'd3, 32'h0000_000A);
        @(negedge clk);
        sel = 2'd2; s2 = 32'h0000_000B; rd_addr = 5'd4;
        expect_write(5'd4, 32'h0000_000B);
        @(negedge clk);
        in_valid = 1'b0;

        // rd_addr 0 with PC source: no write, outputs hold
        @(negedge clk);
        in_valid = 1'b1; sel = 2'd2; s2 = 32'h0000_0104; rd_addr = 5'd0;
        @(negedge clk);
        in_valid = 1'b0;
        check("rd0_hold_data", wb_data,      32'h0000_000B);
        check("rd0_hold_addr", 32'(wb_addr), 32'd4);

        // Out-of-range select picks source 0
        @(negedge clk);
        in_valid = 1'b1; sel = 2'd3; s0 = 32'h0000_5555; s1 = 32'h1111_1111; s2 = 32'h2222_2222; rd_addr = 5'd9;
        expect_write(5'd9, 32'h0000_5555);
        @(negedge clk);
        in_valid = 1'b0;

        // Memory select without reg_write is a plain non-load
        @(negedge clk);
        in_valid = 1'b1; sel = 2'd1; reg_write = 1'b0; rd_addr = 5'd13;
        @(negedge clk);
        in_valid = 1'b0; reg_write = 1'b1;
        check("noreg_in_ready", 32'(in_ready), 32'd1);

        // Load with data three cycles later; rd_addr changes during the wait
        @(negedge clk);
        in_valid = 1'b1; sel = 2'd1; rd_addr = 5'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0; rd_addr = 5'd31;
            check("load_stall", 32'(stall), 32'd1);
            if (i == 2) begin
                mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
                expect_write(5'd7, 32'hDEAD_BEEF);
            end
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("load_in_ready", 32'(in_ready), 32'd1);

        // Load data present at accept
        @(negedge clk);
        in_valid = 1'b1; sel = 2'd1; rd_addr = 5'd8; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
        expect_write(5'd8, 32'h1122_3344);
        @(negedge clk);
        in_valid = 1'b0; mem_rvalid = 1'b0;
        check("fastload_in_ready", 32'(in_ready), 32'd1);

        // Stray mem_rvalid in IDLE is ignored
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
        @(negedge clk);
        mem_rvalid = 1'b0;

        // Timeout: TIMEOUT+1 stall cycles, then a pulse one cycle later
        @(negedge clk);
        in_valid = 1'b1; sel = 2'd1; rd_addr = 5'd10;
        exp_q.push_back('{EV_TIMEOUT, 5'd0, 32'd0, cyc + 6});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("timeout_stall", 32'(stall), 32'd1);
        end
        @(negedge clk);
        check("timeout_in_ready", 32'(in_ready), 32'd1);

        // Data on the timeout cycle wins over the timeout
        @(negedge clk);
        in_valid = 1'b1; sel = 2'd1; rd_addr = 5'd11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("edge_stall", 32'(stall), 32'd1);
            if (i == 4) begin
                mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
                expect_write(5'd11, 32'hCAFE_0001);
            end
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("edge_in_ready", 32'(in_ready), 32'd1);

        // Load to x0 still waits, but never writes
        @(negedge clk);
        in_valid = 1'b1; sel = 2'd1; rd_addr = 5'd0;
        @(negedge clk);
        in_valid = 1'b0;
        check("x0_load_stall", 32'(stall), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("x0_load_in_ready", 32'(in_ready), 32'd1);
        check("x0_load_hold",     wb_data,       32'hCAFE_0001);

        // Reset during WAIT_MEM drops the load
        @(negedge clk);
        in_valid = 1'b1; sel = 2'd1; rd_addr = 5'd12;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_wait_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midload_reset");
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0099;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (8) @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

`ifdef WB_LOAD_EXT_EN
        // Signed byte, data at accept
        @(negedge clk);
        in_valid = 1'b1; sel = 2'd1; rd_addr = 5'd14; load_size = LS_BYTE; load_unsigned = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0080;
        expect_write(5'd14, 32'hFFFF_FF80);
        // Unsigned byte; attributes change during the wait and must be ignored
        @(negedge clk);
        mem_rvalid = 1'b0; rd_addr = 5'd15; load_unsigned = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; load_unsigned = 1'b0; load_size = LS_WORD;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0080;
        expect_write(5'd15, 32'h0000_0080);
        @(negedge clk);
        mem_rvalid = 1'b0;
        // Signed then unsigned half
        @(negedge clk);
        in_valid = 1'b1; rd_addr = 5'd16; load_size = LS_HALF; load_unsigned = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_8001;
        expect_write(5'd16, 32'hFFFF_8001);
        @(negedge clk);
        rd_addr = 5'd17; load_unsigned = 1'b1; mem_rdata = 32'hABCD_8001;
        expect_write(5'd17, 32'h0000_8001);
        @(negedge clk);
        in_valid = 1'b0; mem_rvalid = 1'b0; load_size = LS_WORD; load_unsigned = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
